mem_responder: RTL

Word-addressed RAM target that answers the CPU control unit's memory handshake (`r_enable`/`w_enable`/`address`/`word_in` in, `word_out`/`rdy` out). It sits on the CPU memory bus as the responding end: it accepts one read or write at a time, inserts a programmable number of wait states, and signals completion with a rising edge on `rdy`. After reset it self-clears its storage before accepting traffic, and it flags illegal accesses on a sticky fault output.

---
 rtl/mem_pkg.sv | 17 +
 rtl/ram_array.sv | 24 ++
 rtl/mem_responder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// Word width, fill value and latency bounds live here.
package mem_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] FILL_WORD = 32'h0;
  localparam int MAX_LATENCY = 15;
  localparam int CNT_W = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous word storage.
// Read data is registered; contents are never reset.
module ram_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write-first is irrelevant: reads and writes never share a cycle.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Bus-side RAM target with wait states and self-clear.
// One access at a time; illegal accesses set a sticky fault.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_enable,
  input  logic              w_enable,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] word_in,
  output logic [WORD_W-1:0] word_out,
  output logic              rdy,
  output logic              fault
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY - 1);
  localparam logic [WORD_W-1:0] LIMIT = WORD_W'(DEPTH);

  state_t            state;
  logic [AW-1:0]     ptr;
  logic [CNT_W-1:0]  cnt;
  logic              op_wr;
  logic              op_both;
  logic              op_oor;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] data_q;

  logic              ram_we;
  logic [AW-1:0]     ram_idx;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;

  ram_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .idx  (ram_idx),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Port mux: clear during INIT, prefetch live address in IDLE.
  always_comb begin
    ram_we    = 1'b0;
    ram_idx   = idx_q;
    ram_wdata = data_q;
    unique case (state)
      INIT: begin
        ram_we    = 1'b1;
        ram_idx   = ptr;
        ram_wdata = FILL_WORD;
      end
      IDLE: ram_idx = address[AW-1:0];
      BUSY: ram_we = (cnt == '0) && op_wr && !op_oor;
      default: ;
    endcase
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      rdy      <= 1'b0;
      word_out <= '0;
      fault    <= 1'b0;
      ptr      <= '0;
      cnt      <= '0;
      op_wr    <= 1'b0;
      op_both  <= 1'b0;
      op_oor   <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
    end else begin
      unique case (state)
        INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            state <= IDLE;
            rdy   <= 1'b1;
          end
        end
        IDLE: begin
          if (r_enable || w_enable) begin
            op_wr   <= w_enable;
            op_both <= r_enable && w_enable;
            op_oor  <= address >= LIMIT;
            idx_q   <= address[AW-1:0];
            data_q  <= word_in;
            cnt     <= LOAD;
            rdy     <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rdy   <= 1'b1;
            state <= RESP;
            if (!op_wr)
              word_out <= op_oor ? '0 : ram_rdata;
            if (op_oor || op_both)
              fault <= 1'b1;
          end
        end
        RESP: begin
          if (!r_enable && !w_enable)
            state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
